split_mux_sched: RTL and testbench
==================================

Name: split_mux_sched

Overview:
Round-robin scheduler that shares one split_mux instance among CNT requesters.
- Drives the mux one-hot sel.
- Supports multi-beat bursts with grant lock.
- Gates issue on downstream credits.
- Delays the winner ID through a pipeline matching the mux latency, so every mux output beat is tagged with its source requester.
- Sits directly in front of split_mux; the output tag pipeline runs alongside dout/dout_vld.

Parameters:
CNT, 31, number of requesters / mux inputs
SKIP_DFF_0, 0, must match the split_mux instance; 1 removes the first mux register stage
SKIP_DFF_1, 0, must match the split_mux instance; 1 removes the second mux register stage
CREDITS, 4, maximum beats issued but not yet credit-returned by the downstream consumer
IDW (localparam), $clog2(CNT), width of the requester ID
LAT (localparam), 2-SKIP_DFF_0-SKIP_DFF_1, mux latency in cycles (0..2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_vld  in  CNT  per-requester beat valid
req_last  in  CNT  per-requester last beat of burst
req_rdy  out  CNT  per-requester accept; at most one bit set
mux_sel  out  CNT  one-hot or zero select to split_mux sel; equals req_vld & req_rdy
mux_dout_vld  in  1  split_mux dout_vld, used for alignment checking
out_vld  out  1  tag valid, aligned with mux dout
out_id  out  IDW  index of the requester that produced the current mux dout
out_last  out  1  last flag of that beat
credit_ret  in  1  downstream frees one beat slot
credit_cnt  out  $clog2(CREDITS+1)  available credits
align_err  out  1  sticky: out_vld != mux_dout_vld
cred_err  out  1  sticky: credit_ret received while credit_cnt==CREDITS

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=ARB, ptr=CNT-1 so requester 0 has first priority;
  - credit_cnt=CREDITS;
  - tag pipeline cleared: out_vld=0, out_id=0, out_last=0;
  - align_err=0, cred_err=0.
  - While rst=1, req_rdy=0 and mux_sel=0. Reset mid-burst abandons the lock silently.
- Accept: a beat is accepted when req_vld[i] & req_rdy[i]. req_rdy is nonzero only if credit_cnt>0.
- State ARB:
  - Winner = first i with req_vld[i] set, searching cyclically from ptr+1 (combinational; req_rdy asserted the same cycle).
  - Accepted with req_last=1: ptr<=winner, stay in ARB.
  - Accepted with req_last=0: owner<=winner, go to LOCK.
- State LOCK:
  - req_rdy = onehot(owner) & (credit_cnt>0); all other requesters are blocked even if the owner drops req_vld. There is no timeout.
  - Accepted beat with req_last=1: ptr<=owner, go to ARB. The next arbitration starts after the owner.
- Credits:
  - Accept without credit_ret: decrement.
  - credit_ret without accept: increment.
  - Both in the same cycle: unchanged.
  - credit_ret at CREDITS is ignored and sets cred_err.
  - At credit_cnt=0 nothing is accepted, and credit_ret in that cycle only increments (no same-cycle accept).
- Tag pipeline:
  - {accept, winner_id, req_last} is delayed LAT cycles to {out_vld, out_id, out_last}.
  - LAT=0 is a combinational pass-through.
  - Pipeline registers are reset, not enable-gated (split_mux has no stall).
- align_err: set on any cycle where out_vld != mux_dout_vld; cleared only by rst.
- Throughput: one beat per cycle when credits are available. Fairness: each requester waits at most CNT-1 bursts.

Decomposition:
- Package split_mux_pkg:
  - state enum {ARB, LOCK};
  - function sm_lat(skip0, skip1) returning the latency;
  - CNT-derived width helper (clog2 wrapper).
- Sub-module split_mux_rr_pick: combinational round-robin picker.
  - Inputs: req[CNT], ptr[IDW].
  - Outputs: gnt[CNT] (one-hot), gnt_id[IDW], any.
  - Used by the scheduler in ARB state.
- Tag delay line: generate loop inside the scheduler; no separate module.

Test Plan:
- Fairness: CNT=4, LAT=2, all req_vld=1111, every beat last=1 -> grants 0,1,2,3,0,... one per cycle while credits last; out_id follows the same sequence 2 cycles later, aligned with mux_dout_vld; align_err stays 0.
- Burst lock: req 1 issues a 3-beat burst while req 2 is also valid -> grants 1,1,1 (last on the 3rd), then 2; req 2 is never granted mid-burst, even when req 1 idles one cycle between beats.
- Credit stall: CREDITS=2, no credit_ret, all requesters valid -> exactly 2 accepts, credit_cnt=0, req_rdy=0. credit_ret pulse -> credit_cnt=1, one more accept next cycle. Simultaneous accept+credit_ret -> count unchanged.
- Latency sweep: SKIP_DFF_{0,1} in {00,01,11} -> tag delay 2/1/0 cycles; no align_err across the sweep.
- Reset mid-LOCK: owner=3 mid-burst, assert rst one cycle -> credit_cnt=CREDITS, out_vld=0, state ARB. Next grant goes to requester 0 when 0 and 3 are both valid.
- Error flags: credit_ret at full -> cred_err=1, count stays CREDITS. Force mux_dout_vld=1 with no issue -> align_err=1, sticky until rst.

Source files
------------

// File: rtl/split_mux_pkg.sv
// Shared types and elaboration helpers for the split_mux scheduler.
// Holds the FSM state encoding, the mux latency rule and the ID width helper.
package split_mux_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } sm_state_e;

    // Mux latency in cycles for a given pair of skip flags (0..2).
    function automatic int sm_lat(input int skip0, input int skip1);
        return 2 - skip0 - skip1;
    endfunction

    // Width of an index into n items; never below one bit.
    function automatic int sm_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/split_mux_rr_pick.sv
// Combinational round-robin picker: first set request searching cyclically
// from ptr+1, returned as a one-hot grant plus its index.
module split_mux_rr_pick
    import split_mux_pkg::*;
#(
    parameter int CNT = 31,
    parameter int IDW = sm_width(CNT)
) (
    input  logic [CNT-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [CNT-1:0] gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    logic [IDW-1:0] idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= CNT; k++) begin
            idx = IDW'((int'(ptr) + k) % CNT);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/split_mux_sched.sv
// Round-robin, burst-locking, credit-gated scheduler in front of split_mux;
// tags every mux output beat with the requester that issued it.
module split_mux_sched
    import split_mux_pkg::*;
#(
    parameter int  CNT        = 31,
    parameter int  SKIP_DFF_0 = 0,
    parameter int  SKIP_DFF_1 = 0,
    parameter int  CREDITS    = 4,
    localparam int IDW        = sm_width(CNT),
    localparam int LAT        = sm_lat(SKIP_DFF_0, SKIP_DFF_1),
    localparam int CW         = $clog2(CREDITS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CNT-1:0] req_vld,
    input  logic [CNT-1:0] req_last,
    output logic [CNT-1:0] req_rdy,
    output logic [CNT-1:0] mux_sel,
    input  logic           mux_dout_vld,
    output logic           out_vld,
    output logic [IDW-1:0] out_id,
    output logic           out_last,
    input  logic           credit_ret,
    output logic [CW-1:0]  credit_cnt,
    output logic           align_err,
    output logic           cred_err
);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           last;
    } tag_t;

    sm_state_e      state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [CW-1:0]  credit_q, credit_d;
    logic           align_err_q, align_err_d;
    logic           cred_err_q, cred_err_d;

    logic [CNT-1:0] pick_gnt, rdy, sel;
    logic [IDW-1:0] pick_id, win_id;
    logic           pick_any, has_credit, accept, acc_last, ret_ok;
    tag_t           tag_in, tag_out;

    split_mux_rr_pick #(.CNT(CNT), .IDW(IDW)) u_pick (
        .req    (req_vld),
        .ptr    (ptr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        has_credit = (credit_q != '0);
        if (state_q == ARB) begin
            rdy    = (has_credit && pick_any) ? pick_gnt : '0;
            win_id = pick_id;
        end else begin
            rdy    = has_credit ? (CNT'(1) << owner_q) : '0;
            win_id = owner_q;
        end
        if (rst) rdy = '0;
        sel      = req_vld & rdy;
        accept   = |sel;
        acc_last = |(sel & req_last);
        tag_in.vld  = accept;
        tag_in.id   = accept ? win_id : '0;
        tag_in.last = acc_last;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (state_q == ARB) begin
                if (acc_last) ptr_d = win_id;
                else begin
                    owner_d = win_id;
                    state_d = LOCK;
                end
            end else if (acc_last) begin
                ptr_d   = owner_q;
                state_d = ARB;
            end
        end

        // A return while already full is dropped and flagged instead.
        ret_ok   = credit_ret && (credit_q != CW'(CREDITS));
        credit_d = credit_q;
        if (accept && !ret_ok)      credit_d = credit_q - 1'b1;
        else if (!accept && ret_ok) credit_d = credit_q + 1'b1;

        cred_err_d  = cred_err_q | (credit_ret && (credit_q == CW'(CREDITS)));
        align_err_d = align_err_q | (tag_out.vld != mux_dout_vld);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= IDW'(CNT - 1);
            owner_q     <= '0;
            credit_q    <= CW'(CREDITS);
            align_err_q <= 1'b0;
            cred_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            credit_q    <= credit_d;
            align_err_q <= align_err_d;
            cred_err_q  <= cred_err_d;
        end
    end

    if (LAT == 0) begin : g_pass
        assign tag_out = tag_in;
    end else begin : g_pipe
        tag_t pipe_q [LAT];
        tag_t pipe_d [LAT];

        always_comb begin
            pipe_d[0] = tag_in;
            for (int k = 1; k < LAT; k++) pipe_d[k] = pipe_q[k-1];
        end

        // NOTE: this delay line is reset, not left as uninitialised storage, since out_vld is read straight after reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
            end else begin
                for (int k = 0; k < LAT; k++) pipe_q[k] <= pipe_d[k];
            end
        end

        assign tag_out = pipe_q[LAT-1];
    end

    assign req_rdy    = rdy;
    assign mux_sel    = sel;
    assign out_vld    = tag_out.vld;
    assign out_id     = tag_out.id;
    assign out_last   = tag_out.last;
    assign credit_cnt = credit_q;
    assign align_err  = align_err_q;
    assign cred_err   = cred_err_q;

endmodule

// File: tb/tb_split_mux_sched.sv
// Directed bench: three schedulers (latency 2/1/0) share one stimulus stream,
// each paired with a small model of the split_mux dout_vld delay.
module tb_split_mux_sched;

    localparam int CNT = 4;
    localparam int CRD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_vld, req_last;
    logic       credit_ret, force_dv;

    logic [3:0] rdy2, sel2, rdy1, sel1, rdy0, sel0;
    logic       ov2, ol2, ae2, ce2, ov1, ol1, ae1, ce1, ov0, ol0, ae0, ce0;
    logic [1:0] id2, cc2, id1, cc1, id0, cc0;
    logic       dv2_a, dv2_b, dv1_a, mdv2, mdv1, mdv0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    split_mux_sched #(.CNT(CNT), .SKIP_DFF_0(0), .SKIP_DFF_1(0), .CREDITS(CRD)) u_d2 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_last(req_last),
        .req_rdy(rdy2), .mux_sel(sel2), .mux_dout_vld(mdv2),
        .out_vld(ov2), .out_id(id2), .out_last(ol2), .credit_ret(credit_ret),
        .credit_cnt(cc2), .align_err(ae2), .cred_err(ce2));

    split_mux_sched #(.CNT(CNT), .SKIP_DFF_0(0), .SKIP_DFF_1(1), .CREDITS(CRD)) u_d1 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_last(req_last),
        .req_rdy(rdy1), .mux_sel(sel1), .mux_dout_vld(mdv1),
        .out_vld(ov1), .out_id(id1), .out_last(ol1), .credit_ret(credit_ret),
        .credit_cnt(cc1), .align_err(ae1), .cred_err(ce1));

    split_mux_sched #(.CNT(CNT), .SKIP_DFF_0(1), .SKIP_DFF_1(1), .CREDITS(CRD)) u_d0 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_last(req_last),
        .req_rdy(rdy0), .mux_sel(sel0), .mux_dout_vld(mdv0),
        .out_vld(ov0), .out_id(id0), .out_last(ol0), .credit_ret(credit_ret),
        .credit_cnt(cc0), .align_err(ae0), .cred_err(ce0));

    // split_mux dout_vld model: |sel delayed by the mux latency.
    always @(posedge clk) begin
        if (rst) begin
            dv2_a <= 1'b0;
            dv2_b <= 1'b0;
            dv1_a <= 1'b0;
        end else begin
            dv2_a <= |sel2;
            dv2_b <= dv2_a;
            dv1_a <= |sel1;
        end
    end
    assign mdv2 = dv2_b | force_dv;
    assign mdv1 = dv1_a;
    assign mdv0 = |sel0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_vld = 4'hF; req_last = 4'hF; credit_ret = 1'b0; force_dv = 1'b0;
        step(); step();
        chk("rst_rdy", rdy2, 4'h0);
        chk("rst_sel", sel2, 4'h0);
        chk("rst_credit", cc2, CRD);
        chk("rst_out_vld", ov2, 1'b0);
        chk("rst_out_id", id2, 2'd0);
        chk("rst_out_last", ol2, 1'b0);
        chk("rst_align_err", ae2, 1'b0);
        chk("rst_cred_err", ce2, 1'b0);

        // Fairness: all valid, single-beat bursts, credits returned after the first beat.
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            credit_ret = (c != 0);
            #1;
            chk("fair_sel", sel2, 32'(1) << (c % 4));
            chk("fair_rdy", rdy2, 32'(1) << (c % 4));
            chk("fair_credit", cc2, (c == 0) ? 2 : 1);
            chk("fair_l0_id", id0, c % 4);
            if (c >= 1) chk("fair_l1_id", id1, (c - 1) % 4);
            if (c >= 2) begin
                chk("fair_l2_vld", ov2, 1'b1);
                chk("fair_l2_id", id2, (c - 2) % 4);
            end
            step();
        end
        chk("fair_align2", ae2, 1'b0);
        chk("fair_align1", ae1, 1'b0);
        chk("fair_align0", ae0, 1'b0);
        chk("fair_cred_err", ce2, 1'b0);
        req_vld = 4'h0; credit_ret = 1'b1; step();
        credit_ret = 1'b0; step();

        // Burst lock: requester 1 sends three beats with an idle gap; requester 2 waits.
        req_vld = 4'b0110; req_last = 4'b0000; #1;
        chk("burst_b0_sel", sel2, 4'b0010); step();
        req_vld = 4'b0100; credit_ret = 1'b1; #1;
        chk("burst_b1_rdy", rdy2, 4'b0010);
        chk("burst_b1_sel", sel2, 4'b0000);
        chk("burst_b1_l2_vld", ov2, 1'b0); step();
        req_vld = 4'b0110; credit_ret = 1'b0; #1;
        chk("burst_b2_sel", sel2, 4'b0010);
        chk("burst_b2_l2_id", id2, 2'd1); step();
        req_last = 4'b0010; credit_ret = 1'b1; #1;
        chk("burst_b3_sel", sel2, 4'b0010);
        chk("burst_b3_l2_vld", ov2, 1'b0); step();
        req_last = 4'b0110; #1;
        chk("burst_b4_sel", sel2, 4'b0100);
        chk("burst_b4_l2_last", ol2, 1'b0); step();
        req_vld = 4'h0; #1;
        chk("burst_b5_credit", cc2, 2'd1);
        chk("burst_b5_l2_id", id2, 2'd1);
        chk("burst_b5_l2_last", ol2, 1'b1); step();
        credit_ret = 1'b0; #1;
        chk("burst_b6_l2_id", id2, 2'd2);
        chk("burst_b6_credit", cc2, 2'd2);

        // Credit stall with no returns, then single return, then accept+return together.
        req_vld = 4'hF; req_last = 4'hF; #1;
        chk("stall_s0_sel", sel2, 4'b1000); step();
        chk("stall_s1_sel", sel2, 4'b0001); step();
        chk("stall_s2_credit", cc2, 2'd0);
        chk("stall_s2_rdy", rdy2, 4'h0); step();
        credit_ret = 1'b1; #1;
        chk("stall_s3_sel", sel2, 4'h0); step();
        credit_ret = 1'b0; #1;
        chk("stall_s4_credit", cc2, 2'd1);
        chk("stall_s4_sel", sel2, 4'b0010); step();
        credit_ret = 1'b1; #1;
        chk("stall_s5_credit", cc2, 2'd0); step();
        chk("stall_s6_sel", sel2, 4'b0100); step();
        chk("stall_s7_credit", cc2, 2'd1);
        req_vld = 4'h0; step();
        credit_ret = 1'b0;

        // Reset in the middle of a burst owned by requester 3.
        req_vld = 4'b1001; req_last = 4'b0000; #1;
        chk("lockrst_sel", sel2, 4'b1000); step();
        req_vld = 4'b0001; #1;
        chk("lockrst_blocked_rdy", rdy2, 4'b1000);
        chk("lockrst_blocked_sel", sel2, 4'b0000); step();
        req_vld = 4'b1001; req_last = 4'b1001; rst = 1'b1; step();
        rst = 1'b0; #1;
        chk("lockrst_credit", cc2, CRD);
        chk("lockrst_out_vld", ov2, 1'b0);
        chk("lockrst_sel0", sel2, 4'b0001);
        chk("lockrst_l0_id", id0, 2'd0); step();
        req_vld = 4'h0; credit_ret = 1'b1; step();
        credit_ret = 1'b0; step(); step();
        chk("lockrst_credit_back", cc2, CRD);

        // Error flags: forced dout_vld with nothing issued, then a return at full.
        force_dv = 1'b1; step();
        force_dv = 1'b0; #1;
        chk("align_set", ae2, 1'b1);
        chk("align_other", ae1, 1'b0); step();
        chk("align_sticky", ae2, 1'b1);
        credit_ret = 1'b1; step();
        credit_ret = 1'b0; #1;
        chk("cred_err_set", ce2, 1'b1);
        chk("cred_full_hold", cc2, CRD);
        chk("sweep_align1", ae1, 1'b0);
        chk("sweep_align0", ae0, 1'b0);
        rst = 1'b1; step();
        rst = 1'b0; #1;
        chk("clr_align", ae2, 1'b0);
        chk("clr_cred_err", ce2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
